jtkicker_colmix_n: RTL and testbench



---
 rtl/jtkicker_colmix_n.sv | 104 ++++++++++
 tb/tb_jtkicker_colmix_n.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/jtkicker_colmix_n.sv
// rtl/jtkicker_colmix_n.sv - N-layer priority colour mixer with loadable palette and blank-aligned output
module jtkicker_colmix_n #(
    parameter  int LAYERS = 2,
    parameter  int PW     = 4,
    parameter  int DW     = 8,
    parameter  int RBITS  = 3,
    parameter  int GBITS  = 3,
    parameter  int BBITS  = 2,
    parameter  int DLY    = 3,
    localparam int LW     = (LAYERS > 2) ? $clog2(LAYERS) : 1,
    localparam int AW     = LW + PW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pxl_cen,
    input  logic [LAYERS*PW-1:0] pxl_in,
    input  logic [LAYERS-1:0]    gfx_en,
    input  logic                 LHBL,
    input  logic                 LVBL,
    input  logic [AW-1:0]        prog_addr,
    input  logic [DW-1:0]        prog_data,
    input  logic                 prog_we,
    output logic [3:0]           red,
    output logic [3:0]           green,
    output logic [3:0]           blue,
    output logic                 LHBL_dly,
    output logic                 LVBL_dly
);

    logic [DW-1:0] pal [2**AW];
    logic [LW-1:0] win;
    logic [PW-1:0] win_pen;
    logic [AW-1:0] addr_r;
    logic [DW-1:0] pal_q;
    logic [DLY-1:0] hsr, vsr;
    logic [DLY-1:0] hchain, vchain;
    logic           hnext, vnext;
    logic           unused_bits;

    // Replicate the component MSB-first until 4 bits are filled
    function automatic logic [3:0] expand(input logic [3:0] x, input int bits);
        logic [3:0] res;
        res = '0;
        for (int i = 0; i < 4; i++) begin
            res[3-i] = x[2'(bits - 1 - (i % bits))];
        end
        return res;
    endfunction

    always_comb begin
        win     = LW'(LAYERS - 1);
        win_pen = gfx_en[LAYERS-1] ? pxl_in[(LAYERS-1)*PW +: PW] : '0;
        for (int k = LAYERS - 2; k >= 0; k--) begin
            if (gfx_en[k] && pxl_in[k*PW +: PW] != '0) begin
                win     = LW'(k);
                win_pen = pxl_in[k*PW +: PW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (prog_we) begin
            pal[prog_addr] <= prog_data;
        end
    end

    // The blank gate uses the value the delay line is about to present,
    // so colour and LHBL_dly/LVBL_dly switch on the same tick.
    assign hchain   = DLY'({hsr, LHBL});
    assign vchain   = DLY'({vsr, LVBL});
    assign hnext    = hchain[DLY-1];
    assign vnext    = vchain[DLY-1];
    assign LHBL_dly = hsr[DLY-1];
    assign LVBL_dly = vsr[DLY-1];

    assign unused_bits = ^pal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r <= '0;
            pal_q  <= '0;
            hsr    <= '0;
            vsr    <= '0;
            red    <= '0;
            green  <= '0;
            blue   <= '0;
        end else if (pxl_cen) begin
            addr_r <= {win, win_pen};
            pal_q  <= pal[addr_r];
            hsr    <= hchain;
            vsr    <= vchain;
            if (hnext && vnext) begin
                red   <= expand(4'(pal_q[RBITS-1:0]), RBITS);
                green <= expand(4'(pal_q[RBITS +: GBITS]), GBITS);
                blue  <= expand(4'(pal_q[RBITS+GBITS +: BBITS]), BBITS);
            end else begin
                red   <= '0;
                green <= '0;
                blue  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_jtkicker_colmix_n.sv
// tb/tb_jtkicker_colmix_n.sv - directed vector bench for jtkicker_colmix_n
module tb_jtkicker_colmix_n;

    logic       clk = 1'b0;
    logic       rst_n, pxl_cen, LHBL, LVBL, prog_we;
    logic [7:0] pxl_in;
    logic [1:0] gfx_en;
    logic [4:0] prog_addr;
    logic [7:0] prog_data;

    logic [3:0] ra, ga, ba, rb, gb, bb, rc, gc, bc;
    logic       ha, va, hb, vb, hc, vc;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [3:0] l0;
        logic [3:0] l1;
        logic [1:0] gfx;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    jtkicker_colmix_n dut_a (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .pxl_in(pxl_in), .gfx_en(gfx_en),
        .LHBL(LHBL), .LVBL(LVBL), .prog_addr(prog_addr), .prog_data(prog_data),
        .prog_we(prog_we), .red(ra), .green(ga), .blue(ba), .LHBL_dly(ha), .LVBL_dly(va)
    );

    jtkicker_colmix_n #(.DLY(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .pxl_in(pxl_in), .gfx_en(gfx_en),
        .LHBL(LHBL), .LVBL(LVBL), .prog_addr(prog_addr), .prog_data(prog_data),
        .prog_we(prog_we), .red(rb), .green(gb), .blue(bb), .LHBL_dly(hb), .LVBL_dly(vb)
    );

    jtkicker_colmix_n #(.RBITS(1), .GBITS(1), .BBITS(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .pxl_in(pxl_in), .gfx_en(gfx_en),
        .LHBL(LHBL), .LVBL(LVBL), .prog_addr(prog_addr), .prog_data(prog_data),
        .prog_we(prog_we), .red(rc), .green(gc), .blue(bc), .LHBL_dly(hc), .LVBL_dly(vc)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pal_write(input logic [4:0] addr, input logic [7:0] data);
        prog_addr = addr;
        prog_data = data;
        prog_we   = 1'b1;
        step(1);
        prog_we   = 1'b0;
    endtask

    initial begin
        vecs[0] = '{4'h3, 4'h5, 2'b11, 4'hF, 4'hF, 4'hF};
        vecs[1] = '{4'h0, 4'h5, 2'b11, 4'hF, 4'h0, 4'h0};
        vecs[2] = '{4'h3, 4'h5, 2'b10, 4'hF, 4'h0, 4'h0};
        vecs[3] = '{4'h3, 4'h5, 2'b00, 4'h0, 4'hF, 4'h0};
        vecs[4] = '{4'h5, 4'h0, 2'b11, 4'h4, 4'h6, 4'h5};
        vecs[5] = '{4'h3, 4'h5, 2'b01, 4'hF, 4'hF, 4'hF};
        vecs[6] = '{4'h0, 4'h0, 2'b11, 4'h0, 4'hF, 4'h0};
        vecs[7] = '{4'h6, 4'h0, 2'b11, 4'hB, 4'h0, 4'h0};

        rst_n = 1'b0; pxl_cen = 1'b1; LHBL = 1'b1; LVBL = 1'b1;
        pxl_in = '0; gfx_en = 2'b11; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        #2;
        check("reset_red", {4'h0, ra}, 8'h00);
        check("reset_hdly", {7'h0, ha}, 8'h00);
        check("reset_vdly", {7'h0, va}, 8'h00);
        step(2);
        rst_n = 1'b1;

        pal_write(5'h03, 8'hFF);
        pal_write(5'h15, 8'h07);
        pal_write(5'h10, 8'h38);
        pal_write(5'h05, 8'h5A);
        pal_write(5'h06, 8'h05);
        check("hdly_after_release", {7'h0, ha}, 8'h01);
        check("vdly_after_release", {7'h0, va}, 8'h01);

        foreach (vecs[i]) begin
            pxl_in = {vecs[i].l1, vecs[i].l0};
            gfx_en = vecs[i].gfx;
            step(3);
            check($sformatf("vec%0d_red", i), {4'h0, ra}, {4'h0, vecs[i].r});
            check($sformatf("vec%0d_green", i), {4'h0, ga}, {4'h0, vecs[i].g});
            check($sformatf("vec%0d_blue", i), {4'h0, ba}, {4'h0, vecs[i].b});
        end
        check("bits1_red", {4'h0, rc}, 8'h0F);
        check("bits1_green", {4'h0, gc}, 8'h00);
        check("bits1_blue", {4'h0, bc}, 8'h0F);

        // One-tick horizontal blank, tracked through both delay depths
        pxl_in = {4'h5, 4'h3};
        gfx_en = 2'b11;
        step(3);
        LHBL = 1'b0;
        step(1);
        LHBL = 1'b1;
        for (int e = 0; e < 7; e++) begin
            if (e > 0) step(1);
            check($sformatf("blank_a_e%0d", e), {7'h0, ha}, (e == 2) ? 8'h00 : 8'h01);
            check($sformatf("blank_a_red_e%0d", e), {4'h0, ra}, (e == 2) ? 8'h00 : 8'h0F);
            check($sformatf("blank_b_e%0d", e), {7'h0, hb}, (e == 4) ? 8'h00 : 8'h01);
            check($sformatf("blank_b_red_e%0d", e), {4'h0, rb}, (e == 4) ? 8'h00 : 8'h0F);
        end

        // Asynchronous reset mid-line, no clock edge in between
        rst_n = 1'b0;
        #2;
        check("midreset_red", {4'h0, ra}, 8'h00);
        check("midreset_blue", {4'h0, ba}, 8'h00);
        check("midreset_hdly", {7'h0, ha}, 8'h00);
        rst_n = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            step(1);
            check($sformatf("release_hdly_e%0d", e), {7'h0, ha}, (e == 3) ? 8'h01 : 8'h00);
            check($sformatf("release_red_e%0d", e), {4'h0, ra}, (e == 3) ? 8'h0F : 8'h00);
        end

        // Write to the address being read in S2
        step(2);
        pal_write(5'h03, 8'h00);
        check("coll_pre", {4'h0, ra}, 8'h0F);
        step(1);
        check("coll_old", {4'h0, ra}, 8'h0F);
        step(1);
        check("coll_black", {4'h0, ra}, 8'h00);

        pal_write(5'h03, 8'hFF);
        step(3);
        check("restore_white", {4'h0, ga}, 8'h0F);
        pxl_cen = 1'b0;
        pxl_in  = {4'h0, 4'h5};
        LHBL    = 1'b0;
        step(10);
        check("hold_red", {4'h0, ra}, 8'h0F);
        check("hold_green", {4'h0, ga}, 8'h0F);
        check("hold_blue", {4'h0, ba}, 8'h0F);
        check("hold_hdly", {7'h0, ha}, 8'h01);
        pxl_cen = 1'b1;
        step(3);
        check("resume_blank_red", {4'h0, ra}, 8'h00);
        check("resume_blank_hdly", {7'h0, ha}, 8'h00);
        LHBL = 1'b1;
        step(3);
        check("resume_red", {4'h0, ra}, 8'h04);
        check("resume_green", {4'h0, ga}, 8'h06);
        check("resume_blue", {4'h0, ba}, 8'h05);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
